// File: rtl/stress_pkg.sv
// Shared types, default thresholds and width helpers for the multi-channel stress monitor.
package stress_pkg;

    typedef enum logic [1:0] {
        CALM  = 2'd0,
        ALERT = 2'd1,
        ALARM = 2'd2
    } stress_level_t;

    localparam int N_CH_DEF       = 3;
    localparam int DEB_CYCLES_DEF = 4;
    localparam int SCORE_W_DEF    = 8;
    localparam int DECAY_DIV_DEF  = 16;
    localparam int ALERT_ON_DEF   = 32;
    localparam int ALERT_OFF_DEF  = 16;
    localparam int ALARM_ON_DEF   = 128;
    localparam int ALARM_OFF_DEF  = 96;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int ACT_W_DEF = $clog2(N_CH_DEF + 1);

endpackage

// File: rtl/stress_debounce.sv
// One sensor channel: two-flop synchroniser followed by a stable-run debouncer.
module stress_debounce
    import stress_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sensor,
    output logic o_deb
);

    localparam int              CW       = cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_sensor;
            r_s2 <= r_s1;
            // Any cycle where the synced level agrees restarts the stability run.
            if (r_s2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_deb <= ~r_deb;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/multi_stress_monitor.sv
// N-channel stress monitor: debounced activity count drives a leaky saturating score,
// a hysteretic CALM/ALERT/ALARM level and a software-acknowledged sticky alarm flag.
module multi_stress_monitor
    import stress_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int SCORE_W    = SCORE_W_DEF,
    parameter int DECAY_DIV  = DECAY_DIV_DEF,
    parameter int ALERT_ON   = ALERT_ON_DEF,
    parameter int ALERT_OFF  = ALERT_OFF_DEF,
    parameter int ALARM_ON   = ALARM_ON_DEF,
    parameter int ALARM_OFF  = ALARM_OFF_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [N_CH-1:0]              i_sensor_in,
    input  logic [N_CH-1:0]              i_ch_en,
    input  logic                         i_ack,
    output logic                         o_response,
    output logic [1:0]                   o_level,
    output logic                         o_alarm_latched,
    output logic [SCORE_W-1:0]           o_score,
    output logic [$clog2(N_CH+1)-1:0]    o_active_cnt
);

    localparam int ACT_W = $clog2(N_CH + 1);
    localparam int PW    = cnt_w(DECAY_DIV);

    localparam logic [1:0] ST_CALM  = CALM;
    localparam logic [1:0] ST_ALERT = ALERT;
    localparam logic [1:0] ST_ALARM = ALARM;

    localparam logic [PW-1:0]      PRE_LAST    = PW'(DECAY_DIV - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
    localparam logic [SCORE_W-1:0] TH_ALERT_ON  = SCORE_W'(ALERT_ON);
    localparam logic [SCORE_W-1:0] TH_ALERT_OFF = SCORE_W'(ALERT_OFF);
    localparam logic [SCORE_W-1:0] TH_ALARM_ON  = SCORE_W'(ALARM_ON);
    localparam logic [SCORE_W-1:0] TH_ALARM_OFF = SCORE_W'(ALARM_OFF);

    logic [N_CH-1:0]    w_deb;
    logic [ACT_W-1:0]   w_act;
    logic [SCORE_W:0]   w_sum;
    logic               w_decay_tick;

    logic [PW-1:0]      r_pre;
    logic [SCORE_W-1:0] r_score;
    logic [1:0]         r_level;
    logic               r_alarm_latched;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        stress_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_sensor (i_sensor_in[g]),
            .o_deb    (w_deb[g])
        );
    end

    always_comb begin
        w_act = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_act = w_act + ACT_W'(w_deb[i] & i_ch_en[i]);
        end
    end

    assign w_sum        = {1'b0, r_score} + (SCORE_W + 1)'(w_act);
    assign w_decay_tick = (r_pre == PRE_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= '0;
        end else if (w_decay_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Activity has priority over decay; the extra sum bit catches saturation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_score <= '0;
        end else if (w_act != '0) begin
            r_score <= w_sum[SCORE_W] ? SCORE_MAX : w_sum[SCORE_W-1:0];
        end else if (w_decay_tick && (r_score != '0)) begin
            r_score <= r_score - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= ST_CALM;
        end else begin
            case (r_level)
                ST_CALM: begin
                    if (r_score >= TH_ALARM_ON)      r_level <= ST_ALARM;
                    else if (r_score >= TH_ALERT_ON) r_level <= ST_ALERT;
                end
                ST_ALERT: begin
                    if (r_score >= TH_ALARM_ON)      r_level <= ST_ALARM;
                    else if (r_score < TH_ALERT_OFF) r_level <= ST_CALM;
                end
                ST_ALARM: begin
                    if (r_score < TH_ALERT_OFF)      r_level <= ST_CALM;
                    else if (r_score < TH_ALARM_OFF) r_level <= ST_ALERT;
                end
                default: r_level <= ST_CALM;
            endcase
        end
    end

    // Setting while the level sits in ALARM both marks entry and masks any ack.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alarm_latched <= 1'b0;
        end else if (r_level == ST_ALARM) begin
            r_alarm_latched <= 1'b1;
        end else if (i_ack) begin
            r_alarm_latched <= 1'b0;
        end
    end

    assign o_response      = (r_level != ST_CALM);
    assign o_level         = r_level;
    assign o_alarm_latched = r_alarm_latched;
    assign o_score         = r_score;
    assign o_active_cnt    = w_act;

endmodule

// File: tb/tb_multi_stress_monitor.sv
// Directed bench for multi_stress_monitor at default parameters with hand-computed expectations.
module tb_multi_stress_monitor;

    logic       clk;
    logic       rst_n;
    logic [2:0] sensor_in;
    logic [2:0] ch_en;
    logic       ack;
    logic       response;
    logic [1:0] level;
    logic       alarm_latched;
    logic [7:0] score;
    logic [1:0] active_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    multi_stress_monitor dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_sensor_in     (sensor_in),
        .i_ch_en         (ch_en),
        .i_ack           (ack),
        .o_response      (response),
        .o_level         (level),
        .o_alarm_latched (alarm_latched),
        .o_score         (score),
        .o_active_cnt    (active_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic found;
        rst_n     = 1'b0;
        sensor_in = 3'b000;
        ch_en     = 3'b111;
        ack       = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_score", score, 0);
        chk("rst_level", level, 0);
        chk("rst_resp", response, 0);
        chk("rst_latch", alarm_latched, 0);
        chk("rst_act", active_cnt, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1. Three-cycle glitch must be rejected
        sensor_in = 3'b001;
        repeat (3) tick();
        sensor_in = 3'b000;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("glitch_act", active_cnt, 0);
            chk("glitch_score", score, 0);
            chk("glitch_resp", response, 0);
        end

        // 2. Single channel: debounce latency and +1/cycle
        sensor_in = 3'b001;
        repeat (5) tick();
        chk("ch0_act_t5", active_cnt, 0);
        tick();
        chk("ch0_act_t6", active_cnt, 1);
        chk("ch0_score_t6", score, 0);
        tick();
        chk("ch0_score_t7", score, 1);
        repeat (30) tick();
        chk("ch0_score_t37", score, 31);
        tick();
        chk("ch0_score_t38", score, 32);
        chk("ch0_level_t38", level, 0);
        chk("ch0_resp_t38", response, 0);
        tick();
        chk("ch0_level_t39", level, 1);
        chk("ch0_resp_t39", response, 1);
        chk("ch0_score_t39", score, 33);

        // 3. Full stress, ALARM, saturation, ack ignored in ALARM
        sensor_in = 3'b111;
        repeat (6) tick();
        chk("full_act", active_cnt, 3);
        chk("full_score_t6", score, 39);
        tick();
        chk("full_score_t7", score, 42);
        tick();
        chk("full_score_t8", score, 45);
        repeat (28) tick();
        chk("full_score_t36", score, 129);
        chk("full_level_t36", level, 1);
        tick();
        chk("full_level_t37", level, 2);
        chk("full_latch_t37", alarm_latched, 0);
        tick();
        chk("full_latch_t38", alarm_latched, 1);
        chk("full_resp_t38", response, 1);
        repeat (39) tick();
        chk("sat_score_252", score, 252);
        tick();
        chk("sat_score_255", score, 255);
        tick();
        chk("sat_no_wrap", score, 255);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_in_alarm_latch", alarm_latched, 1);
        chk("ack_in_alarm_level", level, 2);

        // 4. Decay and hysteresis
        sensor_in = 3'b000;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (score == 8'd254) found = 1'b1;
        end
        chk("decay_first_step", found, 1);
        repeat (15) tick();
        chk("decay_hold_15", score, 254);
        tick();
        chk("decay_step_16", score, 253);
        repeat (2527) tick();
        chk("decay_score_96", score, 96);
        chk("decay_level_96", level, 2);
        tick();
        chk("decay_score_95", score, 95);
        chk("decay_level_95", level, 2);
        tick();
        chk("alarm_to_alert", level, 1);
        repeat (1278) tick();
        chk("decay_score_16", score, 16);
        chk("decay_level_16", level, 1);
        tick();
        chk("decay_score_15", score, 15);
        chk("decay_level_15", level, 1);
        tick();
        chk("alert_to_calm", level, 0);
        chk("calm_resp", response, 0);
        chk("calm_latch_kept", alarm_latched, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_clears_latch", alarm_latched, 0);
        chk("ack_level", level, 0);
        repeat (240) tick();
        chk("decay_to_zero", score, 0);
        repeat (20) tick();
        chk("no_underflow", score, 0);

        // 5. Channel masking
        ch_en     = 3'b001;
        sensor_in = 3'b110;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("mask_act", active_cnt, 0);
            chk("mask_score", score, 0);
        end
        ch_en = 3'b111;
        tick();
        chk("unmask_act", active_cnt, 2);
        chk("unmask_score", score, 2);

        // 6. Asynchronous reset in the middle of ALARM
        sensor_in = 3'b111;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (level == 2'd2) found = 1'b1;
        end
        chk("reach_alarm", found, 1);
        tick();
        chk("pre_rst_latch", alarm_latched, 1);
        #3;
        rst_n     = 1'b0;
        sensor_in = 3'b000;
        #1;
        chk("async_resp", response, 0);
        chk("async_level", level, 0);
        chk("async_latch", alarm_latched, 0);
        chk("async_score", score, 0);
        chk("async_act", active_cnt, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("post_rst_score", score, 0);
        chk("post_rst_level", level, 0);
        chk("post_rst_latch", alarm_latched, 0);
        chk("post_rst_resp", response, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
